// File: rtl/sweep_limit_counter.sv
// sweep_limit_counter: drives one servo axis through NUM_PASSES forward/reverse
// passes between position 0 and a latched LIMIT at a prescaled step rate.
//   CLK   - system clock, rising edge
//   RST   - synchronous active-high reset
//   SWEEP - level sweep enable; a new sweep needs a low-then-high transition
//   LIMIT - end position, sampled only when a sweep starts
//   MOVE  - servo move enable, high while stepping
//   DIR   - 0 counting up, 1 counting down
//   POS   - current position
//   PASS  - completed passes in the current sweep
//   BUSY  - high while running
//   DONE  - one-cycle pulse when all passes complete
module sweep_limit_counter #(
    parameter int WIDTH      = 12,
    parameter int PRESCALE   = 1,
    parameter int NUM_PASSES = 2,
    localparam int PASS_W    = $clog2(NUM_PASSES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SWEEP,
    input  logic [WIDTH-1:0]  LIMIT,
    output logic              MOVE,
    output logic              DIR,
    output logic [WIDTH-1:0]  POS,
    output logic [PASS_W-1:0] PASS,
    output logic              BUSY,
    output logic              DONE
);
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state;
    logic [PS_W-1:0]   presc;
    logic [WIDTH-1:0]  lim_q;
    logic [WIDTH-1:0]  pos_nx;
    logic [PASS_W-1:0] pass_nx;
    logic              tick;
    logic              pass_end;
    logic              last;

    // Pass end is judged on the next position so POS never steps past lim_q
    // or below 0, which also keeps an all-ones limit from wrapping.
    always_comb begin
        pos_nx   = DIR ? POS - WIDTH'(1) : POS + WIDTH'(1);
        pass_nx  = PASS + PASS_W'(1);
        tick     = presc == PS_W'(PRESCALE - 1);
        pass_end = DIR ? pos_nx == '0 : pos_nx == lim_q;
        last     = pass_nx == PASS_W'(NUM_PASSES);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            presc <= '0;
            lim_q <= '0;
            MOVE  <= 1'b0;
            DIR   <= 1'b0;
            POS   <= '0;
            PASS  <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (SWEEP) begin
                        POS   <= '0;
                        PASS  <= '0;
                        DIR   <= 1'b0;
                        presc <= '0;
                        if (LIMIT != '0) begin
                            lim_q <= LIMIT;
                            MOVE  <= 1'b1;
                            BUSY  <= 1'b1;
                            state <= RUN;
                        end else begin
                            DONE  <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                RUN: begin
                    if (!SWEEP) begin
                        MOVE  <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        presc <= '0;
                        POS   <= pos_nx;
                        if (pass_end) begin
                            PASS <= pass_nx;
                            if (last) begin
                                MOVE  <= 1'b0;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                                state <= HOLD;
                            end else begin
                                DIR <= ~DIR;
                            end
                        end
                    end else begin
                        presc <= presc + PS_W'(1);
                    end
                end
                HOLD: begin
                    if (!SWEEP) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sweep_limit_counter.sv
// tb_sweep_limit_counter: scoreboard bench for two sweep_limit_counter configurations.
module tb_sweep_limit_counter;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SWEEP = 1'b0;
    logic [3:0] LIMIT = '0;
    logic       MOVE, DIR, BUSY, DONE;
    logic [3:0] POS;
    logic [1:0] PASS;
    logic       SWEEP_B = 1'b0;
    logic [3:0] LIMIT_B = '0;
    logic       MOVE_B, DIR_B, BUSY_B, DONE_B;
    logic [3:0] POS_B;
    logic [0:0] PASS_B;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    sweep_limit_counter #(.WIDTH(4), .PRESCALE(2), .NUM_PASSES(2)) dut_a (
        .CLK(CLK), .RST(RST), .SWEEP(SWEEP), .LIMIT(LIMIT), .MOVE(MOVE), .DIR(DIR),
        .POS(POS), .PASS(PASS), .BUSY(BUSY), .DONE(DONE)
    );

    sweep_limit_counter #(.WIDTH(4), .PRESCALE(1), .NUM_PASSES(1)) dut_b (
        .CLK(CLK), .RST(RST), .SWEEP(SWEEP_B), .LIMIT(LIMIT_B), .MOVE(MOVE_B), .DIR(DIR_B),
        .POS(POS_B), .PASS(PASS_B), .BUSY(BUSY_B), .DONE(DONE_B)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] pk(input bit m, input bit d, input bit b, input bit dn, input int pass, input int pos);
        logic [1:0] p2;
        logic [3:0] p4;
        p2 = pass[1:0];
        p4 = pos[3:0];
        return {6'b0, m, d, b, dn, p2, p4};
    endfunction

    function automatic logic [15:0] obs(input bit b);
        return b ? {6'b0, MOVE_B, DIR_B, BUSY_B, DONE_B, 1'b0, PASS_B, POS_B}
                 : {6'b0, MOVE, DIR, BUSY, DONE, PASS, POS};
    endfunction

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.v = v;
        sb.push_back(e);
    endtask

    // Expected trace of a PRESCALE=2 sweep with limit l, cycles k0..k1 after start
    task automatic push_run(input string tag, input int l, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            int s;
            s = k / 2;
            push(tag, pk(1, s >= l, 1, 0, s >= l ? 1 : 0, s <= l ? s : 2 * l - s));
        end
    endtask

    task automatic step(input bit b);
        exp_t       e;
        logic [15:0] o;
        @(posedge CLK);
        #1;
        o = obs(b);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h required an expectation", o);
        end else begin
            e = sb.pop_front();
            assert (o === e.v) else begin
                errors++;
                $error("FAIL %s: got %h required %h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic steps(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    initial begin
        push("rst_a", pk(0, 0, 0, 0, 0, 0));
        step(0);
        push("rst_b", pk(0, 0, 0, 0, 0, 0));
        step(1);
        RST = 1'b0;

        LIMIT = 4'd3;
        SWEEP = 1'b1;
        push_run("full", 3, 0, 11);
        push("full_done", pk(0, 1, 0, 1, 2, 0));
        steps(0, 13);

        for (int i = 0; i < 20; i++) push("retrig_hold", pk(0, 1, 0, 0, 2, 0));
        steps(0, 20);
        SWEEP = 1'b0;
        push("retrig_idle", pk(0, 1, 0, 0, 2, 0));
        step(0);
        SWEEP = 1'b1;
        push_run("retrig_new", 3, 0, 4);
        steps(0, 5);

        SWEEP = 1'b0;
        push("abort", pk(0, 0, 0, 0, 0, 2));
        push("abort_held", pk(0, 0, 0, 0, 0, 2));
        steps(0, 2);
        SWEEP = 1'b1;
        push_run("abort_restart", 3, 0, 1);
        steps(0, 2);
        SWEEP = 1'b0;
        push("abort_idle", pk(0, 0, 0, 0, 0, 0));
        step(0);

        LIMIT = 4'd7;
        SWEEP = 1'b1;
        push_run("pre_rst", 7, 0, 18);
        steps(0, 19);
        RST = 1'b1;
        push("mid_rst", pk(0, 0, 0, 0, 0, 0));
        step(0);
        RST = 1'b0;
        push_run("post_rst", 7, 0, 1);
        steps(0, 2);
        SWEEP = 1'b0;
        push("post_rst_idle", pk(0, 0, 0, 0, 0, 0));
        step(0);

        LIMIT = 4'd0;
        SWEEP = 1'b1;
        push("zero_done", pk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) push("zero_hold", pk(0, 0, 0, 0, 0, 0));
        steps(0, 4);
        SWEEP = 1'b0;
        push("zero_idle", pk(0, 0, 0, 0, 0, 0));
        step(0);

        LIMIT = 4'd6;
        SWEEP = 1'b1;
        push_run("lim6", 6, 0, 2);
        steps(0, 3);
        LIMIT = 4'd2;
        push_run("lim6_chg", 6, 3, 14);
        steps(0, 12);
        SWEEP = 1'b0;
        push("lim6_abort", pk(0, 1, 0, 0, 1, 5));
        step(0);

        LIMIT_B = 4'd15;
        SWEEP_B = 1'b1;
        for (int k = 0; k < 15; k++) push("max_run", pk(1, 0, 1, 0, 0, k));
        push("max_done", pk(0, 0, 0, 1, 1, 15));
        for (int i = 0; i < 4; i++) push("max_hold", pk(0, 0, 0, 0, 1, 15));
        steps(1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
